// File: rtl/predict_stats_dump_ctrl_pkg.sv
// predict_stats_dump_ctrl_pkg: shared types and constants for the prediction statistics dump path.
package predict_stats_dump_ctrl_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int PREDICT_STAT_NUM = 8;
    localparam logic [7:0] STAT_DUMP_HEADER = 8'hA5;
    localparam int STAT_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(PREDICT_STAT_NUM);
    localparam int BYTE_W = $clog2(STAT_BYTES);
    typedef logic [DATA_WIDTH-1:0] BasicData;
    typedef BasicData [PREDICT_STAT_NUM-1:0] PredictStatVector;
    typedef enum logic [2:0] {
        PSI_BRANCH,
        PSI_PREDICTED_TAKEN,
        PSI_PREDICTED_NOT_TAKEN,
        PSI_CORRECT_BRANCH_PREDICT,
        PSI_NEXT_PC_NOT_PREDICTED,
        PSI_MISS,
        PSI_MISS_OF_TAKEN,
        PSI_MISS_OF_NOT_TAKEN
    } PredictStatIndex;
    typedef enum logic [2:0] {
        SD_IDLE,
        SD_SNAPSHOT,
        SD_HEADER,
        SD_SEND,
        SD_DONE
    } StatDumpState;
endpackage

// File: rtl/predict_stats_dump_ctrl_if.sv
// predict_stats_dump_ctrl_if: byte stream with valid/ready handshake toward the debug output path.
interface predict_stats_dump_ctrl_if;
    logic [7:0] outData;
    logic outValid;
    logic outReady;
    modport master (output outData, output outValid, input outReady);
    modport slave (input outData, input outValid, output outReady);
endinterface

// File: rtl/predict_stats_dump_ctrl_serializer.sv
// predict_stats_dump_ctrl_serializer: shadow copy of the counters plus the byte walk over it.
module predict_stats_dump_ctrl_serializer
    import predict_stats_dump_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  PredictStatVector i_counters,
    input  logic             i_load,
    input  logic             i_adv,
    output logic [7:0]       o_cur_byte,
    output logic [7:0]       o_next_byte,
    output logic             o_last
);
    PredictStatVector r_shadow;
    logic [CNT_W-1:0] r_cnt;
    logic [BYTE_W-1:0] r_byte;
    logic w_byte_last;
    logic [CNT_W-1:0] w_ncnt;
    logic [BYTE_W-1:0] w_nbyte;
    assign w_byte_last = r_byte == BYTE_W'(STAT_BYTES - 1);
    assign w_nbyte = w_byte_last ? '0 : BYTE_W'(r_byte + 1'b1);
    assign w_ncnt = w_byte_last ? CNT_W'(r_cnt + 1'b1) : r_cnt;
    assign o_last = w_byte_last && r_cnt == CNT_W'(PREDICT_STAT_NUM - 1);
    assign o_cur_byte = r_shadow[r_cnt][8*r_byte +: 8];
    // Look-ahead byte lets the controller register outData on the accepting edge.
    assign o_next_byte = r_shadow[w_ncnt][8*w_nbyte +: 8];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_cnt <= '0;
            r_byte <= '0;
        end else if (i_load) begin
            r_shadow <= i_counters;
            r_cnt <= '0;
            r_byte <= '0;
        end else if (i_adv) begin
            r_cnt <= w_ncnt;
            r_byte <= w_nbyte;
        end
    end
endmodule

// File: rtl/predict_stats_dump_ctrl.sv
// predict_stats_dump_ctrl: snapshots the prediction statistics, optionally clears them,
// and streams header plus little-endian counter bytes over a valid/ready link.
module predict_stats_dump_ctrl
    import predict_stats_dump_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dumpReq,
    input  logic                       dumpClear,
    input  logic                       clearReq,
    input  PredictStatVector           counters,
    output logic                       clearCounters,
    output logic                       busy,
    output logic                       dumpDone,
    predict_stats_dump_ctrl_if.master  out
);
    StatDumpState r_state;
    logic w_hs;
    logic [7:0] w_cur_byte;
    logic [7:0] w_next_byte;
    logic w_last;
    assign w_hs = out.outValid && out.outReady;
    predict_stats_dump_ctrl_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_counters  (counters),
        .i_load      (r_state == SD_SNAPSHOT),
        .i_adv       (r_state == SD_SEND && w_hs && !w_last),
        .o_cur_byte  (w_cur_byte),
        .o_next_byte (w_next_byte),
        .o_last      (w_last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SD_IDLE;
            out.outValid <= 1'b0;
            out.outData <= '0;
            busy <= 1'b0;
            clearCounters <= 1'b0;
            dumpDone <= 1'b0;
        end else begin
            clearCounters <= 1'b0;
            dumpDone <= 1'b0;
            case (r_state)
                SD_IDLE: begin
                    // The clear pulse lands in the SNAPSHOT cycle, so the shadow keeps pre-clear values.
                    clearCounters <= dumpReq ? dumpClear | clearReq : clearReq;
                    busy <= dumpReq;
                    r_state <= dumpReq ? SD_SNAPSHOT : SD_IDLE;
                end
                SD_SNAPSHOT: begin
                    r_state <= SD_HEADER;
                    out.outValid <= 1'b1;
                    out.outData <= STAT_DUMP_HEADER;
                end
                SD_HEADER: if (w_hs) begin
                    r_state <= SD_SEND;
                    out.outData <= w_cur_byte;
                end
                SD_SEND: if (w_hs) begin
                    r_state <= w_last ? SD_DONE : SD_SEND;
                    out.outValid <= !w_last;
                    out.outData <= w_last ? 8'h00 : w_next_byte;
                    dumpDone <= w_last;
                end
                SD_DONE: begin
                    r_state <= SD_IDLE;
                    busy <= 1'b0;
                end
                default: r_state <= SD_IDLE;
            endcase
        end
    end
endmodule

// File: doc/predict_stats_dump_ctrl.md
Name: predict_stats_dump_ctrl

Overview:
Controller that sequences the branch-prediction statistics counters in the Debug area. On request it snapshots all eight counters in one cycle and optionally clears them in that same cycle. It then streams the snapshot out as a byte stream with a valid/ready handshake toward the debug output path, such as a UART TX FIFO. It also services stand-alone clear requests, driving a clear pulse into the statistics counter block.

Parameters:
NUM_COUNTERS, 8, number of statistics counters snapshotted and streamed
COUNTER_WIDTH, DATA_WIDTH (32), width of each counter; must be a multiple of 8
HEADER_BYTE, 8'hA5, sync byte emitted before the counter payload

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high (RESET level = 1)
dumpReq  input  1  single-cycle pulse: start snapshot+dump; ignored while busy
dumpClear  input  1  sampled with dumpReq: clear counters at snapshot time
clearReq  input  1  single-cycle pulse: clear counters without dumping
counters  input  NUM_COUNTERS x COUNTER_WIDTH  live counter values; index order fixed: 0 Branch, 1 PredictedTaken, 2 PredictedNotTaken, 3 CorrectBranchPredict, 4 NextPcNotPredicted, 5 Miss, 6 MissOfTaken, 7 MissOfNotTaken
clearCounters  output  1  one-cycle pulse; statistics block zeroes all counters on the following edge
outData  output  8  stream byte
outValid  output  1  outData valid
outReady  input  1  sink accepts byte when outValid && outReady at posedge
busy  output  1  high from cycle after dumpReq until end of DONE
dumpDone  output  1  one-cycle pulse when last byte has been accepted

Behaviour:
- Reset (asynchronous, any state): state=IDLE; outValid=0, outData=0, busy=0, clearCounters=0, dumpDone=0; shadow and index registers zeroed. A reset mid-dump aborts the dump with no further bytes and no dumpDone.
- FSM states: IDLE, SNAPSHOT, HEADER, SEND, DONE.
- IDLE:
  - dumpReq=1: latch clearAfter=dumpClear, go to SNAPSHOT.
  - clearReq=1 without dumpReq: assert clearCounters for exactly this cycle (registered, so visible the next cycle) and remain in IDLE.
  - dumpReq and clearReq in the same cycle: treated as a dump with clearAfter=1.
- SNAPSHOT (1 cycle): shadow[i] <= counters[i] for all i. If clearAfter, clearCounters=1 in this cycle. Counts arriving in the SNAPSHOT cycle are lost by design; no count is double-reported. Go to HEADER.
- HEADER: outValid=1, outData=HEADER_BYTE. On handshake go to SEND with cntIdx=0, byteIdx=0.
- SEND:
  - outData = shadow[cntIdx][8*byteIdx +: 8]. Byte order is little-endian within a counter; counters are sent in ascending index.
  - On handshake, byteIdx increments. At byteIdx = COUNTER_WIDTH/8-1 it wraps to 0 and cntIdx increments.
  - On the handshake of the last byte (cntIdx = NUM_COUNTERS-1, last byteIdx) go to DONE.
- DONE (1 cycle): outValid=0, dumpDone=1, busy=1. Next state is IDLE.
- Handshake rules:
  - Once outValid=1, outData is held stable until accepted.
  - outValid never drops without a handshake, except on reset.
  - outReady may toggle arbitrarily.
- busy=1 in SNAPSHOT, HEADER, SEND and DONE. dumpReq and clearReq are ignored while busy; no queuing.
- Latency: dumpReq at cycle 0 puts the header on outData at cycle 2. With outReady tied to 1, the stream is 1 + NUM_COUNTERS*COUNTER_WIDTH/8 = 33 bytes over cycles 2..34, dumpDone pulses at cycle 35, and the controller is IDLE at cycle 36.
- Shadow values are frozen for the whole dump; live counters may change freely.
- Index counter widths: $clog2(NUM_COUNTERS) for cntIdx and $clog2(COUNTER_WIDTH/8) for byteIdx. Neither may overflow, since wrap is explicit.
- The statistics counter block gains a clear input driven by clearCounters. Clear has priority over increment in the statistics block.

Decomposition:
- DebugTypes package holds:
  - PREDICT_STAT_NUM=8
  - PredictStatIndex enum (the 8 names above)
  - StatDumpState enum
  - STAT_DUMP_HEADER=8'hA5
  - PredictStatVector typedef (array of BasicData)
- One natural sub-module: stat_dump_serializer. It holds the shadow register array, cntIdx/byteIdx, the byte mux and the last-byte flag. predict_stats_dump_ctrl keeps the FSM, request handling and clear pulse.

Test Plan:
- counters[i] = 32'h11223300+i, dumpReq=1, dumpClear=0, outReady=1 → bytes A5, 00 33 22 11, 01 33 22 11, …, 07 33 22 11 (33 total); dumpDone at cycle 35; clearCounters never asserted.
- Same stimulus with dumpClear=1 → clearCounters pulses in the SNAPSHOT cycle (cycle 1) only; streamed values are the pre-clear values.
- outReady toggled pseudo-randomly (~50%) → outData stable while outValid && !outReady; byte sequence identical to the first test; dumpDone after the 33rd accepted byte.
- Counter values change every cycle during the dump → streamed values equal those sampled at SNAPSHOT.
- clearReq in IDLE → one-cycle clearCounters, busy stays 0. clearReq or dumpReq while busy → ignored (no extra pulse, no restart). dumpReq and clearReq together in IDLE → dump with clear.
- Assert rst after 10 accepted bytes → outValid=0 and busy=0 immediately (asynchronous), no dumpDone. A later dumpReq restarts cleanly from HEADER_BYTE.
